ias_fetch_unit: RTL and testbench

- Instruction fetch engine: the reader side of the program counter register.
- Samples the 8-bit PC value and issues a memory read with a req/ack handshake.
- Buffers the returned 40-bit word and hands its left, then right, 20-bit instruction to decode over a valid/ready handshake.
- Pulses an increment back to the PC; a flush input redirects fetch after a branch.

---
 rtl/ias_fetch_unit.sv | 103 ++++++++++
 tb/tb_ias_fetch_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ias_fetch_unit.sv
// Instruction fetch engine: reads a 40-bit word at the PC, then presents its
// left and right 20-bit instructions to decode, pulsing pc_inc once per word.
module ias_fetch_unit #(
   parameter int ADDR_W = 8,
   parameter int OPC_W = 8,
   parameter int OPR_W = 12,
   localparam int HALF_W = OPC_W + OPR_W,
   localparam int WORD_W = 2 * HALF_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  logic [ADDR_W-1:0] pc_in,
   output logic              pc_inc,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [OPC_W-1:0]  instr_opcode,
   output logic [OPR_W-1:0]  instr_addr,
   output logic              instr_is_right,
   output logic              busy
);

   // Handshake: an instruction transfers on a rising edge where instr_valid
   // and instr_ready are both 1 and flush is 0; valid and fields then hold
   // until that transfer (or flush/rst), and valid never depends on ready.

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      SETUP      = 3'd1,
      REQ        = 3'd2,
      FLUSH_WAIT = 3'd3,
      ISSUE_L    = 3'd4,
      ISSUE_R    = 3'd5
   } state_t;

   state_t state;
   state_t state_next;

   logic [WORD_W-1:0] word_buf;
   logic              first_l;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:       if (start) state_next = SETUP;
         SETUP:      if (!flush) state_next = REQ;
         REQ: begin
            if (flush)        state_next = mem_ack ? SETUP : FLUSH_WAIT;
            else if (mem_ack) state_next = ISSUE_L;
         end
         FLUSH_WAIT: if (mem_ack) state_next = SETUP;
         ISSUE_L: begin
            if (flush)            state_next = SETUP;
            else if (instr_ready) state_next = ISSUE_R;
         end
         ISSUE_R: begin
            if (flush)            state_next = SETUP;
            else if (instr_ready) state_next = start ? SETUP : IDLE;
         end
         default:                 state_next = IDLE;
      endcase
   end

   // Address is latched as SETUP exits so a PC update from the prior cycle is seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_addr <= '0;
         word_buf <= '0;
         first_l  <= 1'b0;
      end else begin
         if (state == SETUP && state_next == REQ) mem_addr <= pc_in;
         if (state == REQ && mem_ack && !flush)   word_buf <= mem_rdata;
         first_l <= (state == REQ) && (state_next == ISSUE_L);
      end
   end

   always_comb begin
      mem_req        = (state == REQ) || (state == FLUSH_WAIT);
      instr_valid    = (state == ISSUE_L) || (state == ISSUE_R);
      instr_is_right = (state == ISSUE_R);
      busy           = (state != IDLE);
      // A flush in the first issue cycle means a branch target is being loaded.
      pc_inc         = first_l && !flush;
      if (state == ISSUE_R) begin
         instr_opcode = word_buf[HALF_W-1 -: OPC_W];
         instr_addr   = word_buf[OPR_W-1:0];
      end else begin
         instr_opcode = word_buf[WORD_W-1 -: OPC_W];
         instr_addr   = word_buf[HALF_W+OPR_W-1 -: OPR_W];
      end
   end

endmodule

// File: tb/tb_ias_fetch_unit.sv
// Bench for ias_fetch_unit: PC register and memory models, an address queue
// checked at each new request, and an instruction queue checked at handshakes.
module tb_ias_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        flush;
  logic [7:0]  pc;
  logic        pc_inc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [39:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [11:0] instr_addr;
  logic        instr_is_right;
  logic        busy;

  logic        pc_load;
  logic [7:0]  pc_load_val;
  int          mem_wait;
  logic [39:0] mem [256];

  logic [20:0] exp_q[$];
  logic [7:0]  exp_addr_q[$];

  int pass_cnt = 0;
  int total_cnt = 0;
  int pc_inc_cnt = 0;

  ias_fetch_unit dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .pc_in(pc),
    .pc_inc(pc_inc), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_opcode(instr_opcode),
    .instr_addr(instr_addr), .instr_is_right(instr_is_right), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // PC register model
  always @(posedge clk) begin
    if (pc_load)     pc <= pc_load_val;
    else if (pc_inc) pc <= pc + 8'd1;
  end

  // memory model: acks after mem_wait extra cycles, checks address and stability
  int          req_cnt = 0;
  int          req_wait = 0;
  bit          in_req = 0;
  logic [7:0]  cur_addr;

  always @(negedge clk) begin
    if (mem_req && !rst) begin
      if (!in_req) begin
        in_req = 1;
        req_cnt = 0;
        req_wait = mem_wait;
        cur_addr = mem_addr;
        if (exp_addr_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_req: got addr %h expected no request", mem_addr);
        end else begin
          check("req_addr", mem_addr, exp_addr_q.pop_front());
        end
      end else begin
        check("req_addr_stable", mem_addr, cur_addr);
      end
      if (req_cnt == req_wait) begin
        mem_ack = 1'b1;
        mem_rdata = mem[mem_addr];
        in_req = 0;
      end else begin
        mem_ack = 1'b0;
        req_cnt++;
      end
    end else begin
      mem_ack = 1'b0;
      in_req = 0;
    end
  end

  // scoreboard monitor: compares every accepted instruction
  always @(negedge clk) begin
    if (!rst) begin
      if (pc_inc) pc_inc_cnt++;
      if (instr_valid && instr_ready && !flush) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_instr: got %h expected none",
                   {instr_is_right, instr_opcode, instr_addr});
        end else begin
          check("instr", {instr_is_right, instr_opcode, instr_addr}, exp_q.pop_front());
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [7:0] v);
    pc_load = 1'b1;
    pc_load_val = v;
    cyc();
    pc_load = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    @(negedge clk);
    while (!mem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, mem_req, 1'b1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!instr_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, instr_valid, 1'b1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_pc_inc"}, pc_inc, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_opcode"}, instr_opcode, 0);
    check({tag, "_addr"}, instr_addr, 0);
    check({tag, "_is_right"}, instr_is_right, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; instr_ready = 1'b0;
    mem_wait = 0; pc_load = 1'b0; pc_load_val = 8'h00;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 40'h0;
    mem[8'h10] = 40'hAB123_CD456;
    mem[8'h11] = 40'h11AAA_22BBB;
    mem[8'h20] = 40'h5A0F0_3C789;
    mem[8'h21] = 40'hEEEEE_EEEEE;
    mem[8'h40] = 40'h12345_6789A;
    mem[8'h41] = 40'h0F0F0_F0F0F;
    mem[8'h50] = 40'h77AA5_88BB6;
    mem[8'h51] = 40'h13579_2468A;
    mem[8'h60] = 40'hC0FFE_BEEF1;
    mem[8'h61] = 40'h2468A_13579;

    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    load_pc(8'h10);

    // 1: zero-wait fetch, exact latency, then start dropped during the next REQ
    instr_ready = 1'b1;
    exp_addr_q.push_back(8'h10);
    exp_addr_q.push_back(8'h11);
    exp_q.push_back(21'h0_AB123);
    exp_q.push_back(21'h1_CD456);
    exp_q.push_back(21'h0_11AAA);
    exp_q.push_back(21'h1_22BBB);
    start = 1'b1;
    @(negedge clk); check("t1_c0_busy", busy, 0);
    @(negedge clk); check("t1_c1_req", mem_req, 0); check("t1_c1_busy", busy, 1);
    @(negedge clk); check("t1_c2_req", mem_req, 1); check("t1_c2_addr", mem_addr, 8'h10);
    @(negedge clk); check("t1_c3_valid", instr_valid, 1); check("t1_c3_pc_inc", pc_inc, 1);
    check("t1_c3_right", instr_is_right, 0);
    @(negedge clk); check("t1_c4_right", instr_is_right, 1); check("t1_c4_pc_inc", pc_inc, 0);
    @(negedge clk); check("t1_c5_req", mem_req, 0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); check("t1_c6_req", mem_req, 1); check("t1_c6_addr", mem_addr, 8'h11);
    wait_idle("t1_idle");
    repeat (4) @(negedge clk);
    check("t1_still_idle", busy, 0);
    check("t1_no_req", mem_req, 0);
    check("t1_pc", pc, 8'h12);

    // 2: 5-cycle memory wait and decode back-pressure on the left half
    @(posedge clk); #1;
    load_pc(8'h20);
    instr_ready = 1'b0;
    mem_wait = 5;
    exp_addr_q.push_back(8'h20);
    exp_q.push_back(21'h0_5A0F0);
    exp_q.push_back(21'h1_3C789);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_valid("t2_valid");
    check("t2_pc_inc_first", pc_inc, 1);
    check("t2_left_first", instr_is_right, 0);
    repeat (2) begin
      @(negedge clk);
      check("t2_hold_valid", instr_valid, 1);
      check("t2_hold_left", instr_is_right, 0);
      check("t2_hold_fields", {instr_opcode, instr_addr}, 20'h5A0F0);
      check("t2_hold_pc_inc", pc_inc, 0);
    end
    @(posedge clk); #1;
    instr_ready = 1'b1;
    wait_idle("t2_idle");
    check("t2_pc", pc, 8'h21);

    // 3: flush in REQ with a slow ack, branch to 8'h40
    @(posedge clk); #1;
    mem_wait = 3;
    exp_addr_q.push_back(8'h21);
    exp_addr_q.push_back(8'h40);
    exp_q.push_back(21'h0_12345);
    exp_q.push_back(21'h1_6789A);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_req("t3_req");
    @(posedge clk); #1;
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 8'h40;
    @(posedge clk); #1;
    flush = 1'b0; pc_load = 1'b0; mem_wait = 0;
    @(negedge clk);
    check("t3_fw_req", mem_req, 1);
    check("t3_fw_addr", mem_addr, 8'h21);
    check("t3_fw_valid", instr_valid, 0);
    wait_idle("t3_idle");
    check("t3_pc", pc, 8'h41);

    // 4a: flush in the first ISSUE_L cycle
    @(posedge clk); #1;
    exp_addr_q.push_back(8'h41);
    exp_addr_q.push_back(8'h50);
    exp_q.push_back(21'h0_77AA5);
    exp_q.push_back(21'h1_88BB6);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_req("t4a_req");
    @(posedge clk); #1;
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 8'h50;
    @(negedge clk);
    check("t4a_valid", instr_valid, 1);
    check("t4a_pc_inc", pc_inc, 0);
    @(posedge clk); #1;
    flush = 1'b0; pc_load = 1'b0;
    @(negedge clk);
    check("t4a_valid_drop", instr_valid, 0);
    wait_idle("t4a_idle");
    check("t4a_pc", pc, 8'h51);

    // 4b: flush coincident with the ISSUE_R handshake
    @(posedge clk); #1;
    exp_addr_q.push_back(8'h51);
    exp_addr_q.push_back(8'h60);
    exp_q.push_back(21'h0_13579);
    exp_q.push_back(21'h0_C0FFE);
    exp_q.push_back(21'h1_BEEF1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_req("t4b_req");
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1; pc_load = 1'b1; pc_load_val = 8'h60;
    @(negedge clk);
    check("t4b_right", instr_is_right, 1);
    check("t4b_valid", instr_valid, 1);
    @(posedge clk); #1;
    flush = 1'b0; pc_load = 1'b0;
    @(negedge clk);
    check("t4b_valid_drop", instr_valid, 0);
    wait_idle("t4b_idle");
    check("t4b_pc", pc, 8'h61);

    // 6: asynchronous reset mid-REQ, then mid-ISSUE_R
    @(posedge clk); #1;
    mem_wait = 4;
    exp_addr_q.push_back(8'h61);
    exp_addr_q.push_back(8'h61);
    exp_q.push_back(21'h0_2468A);
    start = 1'b1;
    wait_req("t6_req");
    #2 rst = 1'b1;
    #1 check_zero("rst_req");
    @(posedge clk); #1;
    rst = 1'b0;
    mem_wait = 0;
    wait_req("t6_refetch");
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    instr_ready = 1'b0;
    @(negedge clk);
    check("t6_right", instr_is_right, 1);
    #2 rst = 1'b1;
    #1 check_zero("rst_issue_r");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_idle_busy", busy, 0);
    check("t6_idle_req", mem_req, 0);
    check("t6_pc", pc, 8'h62);

    // final report
    check("exp_q_empty", exp_q.size(), 0);
    check("exp_addr_q_empty", exp_addr_q.size(), 0);
    check("pc_inc_count", pc_inc_cnt, 8);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
